// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with WB write-through bypass, load-use stall and flush
module id_ex_stage #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_valid,
    input  logic [AW-1:0]  id_rs,
    input  logic [AW-1:0]  id_rt,
    input  logic [AW-1:0]  id_dest,
    input  logic [DW-1:0]  id_imm,
    input  logic [7:0]     id_ctrl,
    input  logic [OPW-1:0] id_alu_op,
    input  logic [DW-1:0]  rf_data1,
    input  logic [DW-1:0]  rf_data2,
    input  logic           wb_write,
    input  logic [AW-1:0]  wb_reg,
    input  logic [DW-1:0]  wb_data,
    input  logic           flush,
    output logic           stall_out,
    output logic           ex_valid,
    output logic [AW-1:0]  ex_rs,
    output logic [AW-1:0]  ex_rt,
    output logic [AW-1:0]  ex_dest,
    output logic [DW-1:0]  ex_data1,
    output logic [DW-1:0]  ex_data2,
    output logic [DW-1:0]  ex_imm,
    output logic [7:0]     ex_ctrl,
    output logic [OPW-1:0] ex_alu_op
);

    // Bit positions inside {reg_write,mem_read,mem_write,mem_to_reg,alu_src,branch,jump,shift}
    localparam int CTRL_MEM_READ  = 6;
    localparam int CTRL_MEM_WRITE = 5;
    localparam int CTRL_ALU_SRC   = 3;

    logic           valid_q,  valid_d;
    logic [AW-1:0]  rs_q,     rs_d;
    logic [AW-1:0]  rt_q,     rt_d;
    logic [AW-1:0]  dest_q,   dest_d;
    logic [DW-1:0]  data1_q,  data1_d;
    logic [DW-1:0]  data2_q,  data2_d;
    logic [DW-1:0]  imm_q,    imm_d;
    logic [7:0]     ctrl_q,   ctrl_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;

    logic [DW-1:0]  op1, op2;
    logic           rt_used;
    logic           load_use;

    // The rf only commits on the edge, so a same-cycle WB write must be forwarded here.
    always_comb begin
        op1 = rf_data1;
        op2 = rf_data2;
        if (id_rs == '0) begin
            op1 = '0;
        end else if (wb_write && (wb_reg == id_rs)) begin
            op1 = wb_data;
        end
        if (id_rt == '0) begin
            op2 = '0;
        end else if (wb_write && (wb_reg == id_rt)) begin
            op2 = wb_data;
        end
    end

    // rt is a real source unless replaced by the immediate; stores always read it.
    always_comb begin
        rt_used  = !id_ctrl[CTRL_ALU_SRC] || id_ctrl[CTRL_MEM_WRITE];
        load_use = valid_q && ctrl_q[CTRL_MEM_READ] && (dest_q != '0) && id_valid &&
                   ((dest_q == id_rs) || ((dest_q == id_rt) && rt_used));
    end

    always_comb begin
        valid_d  = valid_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        dest_d   = dest_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        imm_d    = imm_q;
        ctrl_d   = ctrl_q;
        alu_op_d = alu_op_q;
        if (flush || load_use) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else begin
            valid_d  = id_valid;
            rs_d     = id_rs;
            rt_d     = id_rt;
            dest_d   = id_dest;
            data1_d  = op1;
            data2_d  = op2;
            imm_d    = id_imm;
            ctrl_d   = id_valid ? id_ctrl : 8'h00;
            alu_op_d = id_alu_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            rs_q     <= '0;
            rt_q     <= '0;
            dest_q   <= '0;
            data1_q  <= '0;
            data2_q  <= '0;
            imm_q    <= '0;
            ctrl_q   <= '0;
            alu_op_q <= '0;
        end else begin
            valid_q  <= valid_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            dest_q   <= dest_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            imm_q    <= imm_d;
            ctrl_q   <= ctrl_d;
            alu_op_q <= alu_op_d;
        end
    end

    assign stall_out = load_use;
    assign ex_valid  = valid_q;
    assign ex_rs     = rs_q;
    assign ex_rt     = rt_q;
    assign ex_dest   = dest_q;
    assign ex_data1  = data1_q;
    assign ex_data2  = data2_q;
    assign ex_imm    = imm_q;
    assign ex_ctrl   = ctrl_q;
    assign ex_alu_op = alu_op_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int OPW = 4;

    localparam logic [7:0] C_ADD  = 8'h80; // reg_write
    localparam logic [7:0] C_ADDI = 8'h88; // reg_write, alu_src
    localparam logic [7:0] C_LW   = 8'hD8; // reg_write, mem_read, mem_to_reg, alu_src
    localparam logic [7:0] C_SW   = 8'h28; // mem_write, alu_src

    logic           clk = 1'b0;
    logic           rst_n;
    logic           id_valid;
    logic [AW-1:0]  id_rs, id_rt, id_dest;
    logic [DW-1:0]  id_imm;
    logic [7:0]     id_ctrl;
    logic [OPW-1:0] id_alu_op;
    logic [DW-1:0]  rf_data1, rf_data2;
    logic           wb_write;
    logic [AW-1:0]  wb_reg;
    logic [DW-1:0]  wb_data;
    logic           flush;
    logic           stall_out;
    logic           ex_valid;
    logic [AW-1:0]  ex_rs, ex_rt, ex_dest;
    logic [DW-1:0]  ex_data1, ex_data2, ex_imm;
    logic [7:0]     ex_ctrl;
    logic [OPW-1:0] ex_alu_op;

    int checks   = 0;
    int failures = 0;

    id_ex_stage #(.DW(DW), .AW(AW), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .id_alu_op(id_alu_op),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data),
        .flush(flush), .stall_out(stall_out),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
        .ex_ctrl(ex_ctrl), .ex_alu_op(ex_alu_op)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic [AW-1:0] dest, input logic [7:0] ctrl,
                          input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        id_valid  = v;
        id_rs     = rs;
        id_rt     = rt;
        id_dest   = dest;
        id_ctrl   = ctrl;
        rf_data1  = d1;
        rf_data2  = d2;
        id_imm    = 32'h0000_0010;
        id_alu_op = 4'h0;
        #1;
    endtask

    task automatic clear_inputs();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 8'h00, 32'd0, 32'd0);
        wb_write = 1'b0;
        wb_reg   = 5'd0;
        wb_data  = 32'd0;
        flush    = 1'b0;
        #1;
    endtask

    // Empty EX, then load an instruction into it.
    task automatic load_ex(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                           input logic [AW-1:0] dest, input logic [7:0] ctrl);
        clear_inputs();
        tick();
        set_id(1'b1, rs, rt, dest, ctrl, 32'd1, 32'd2);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        checks++;
        if ({ex_valid, ex_rs, ex_rt, ex_dest, ex_data1, ex_data2, ex_imm, ex_ctrl, ex_alu_op} !== '0) begin
            failures++;
            $display("FAIL reset_init: ex_valid=%0b ex_ctrl=%h ex_data1=%h got nonzero, required all 0",
                     ex_valid, ex_ctrl, ex_data1);
        end
        #2 rst_n = 1'b1;
        load_ex(5'd1, 5'd2, 5'd4, C_LW);
        set_id(1'b1, 5'd4, 5'd5, 5'd6, C_ADD, 32'd3, 32'd4);
        checks++;
        if (ex_valid !== 1'b1 || stall_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre: ex_valid=%0b stall_out=%0b, required 1 1", ex_valid, stall_out);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ex_valid, ex_rs, ex_rt, ex_dest, ex_data1, ex_data2, ex_imm, ex_ctrl, ex_alu_op} !== '0) begin
            failures++;
            $display("FAIL reset_async: ex_valid=%0b ex_dest=%0d ex_ctrl=%h, required all 0",
                     ex_valid, ex_dest, ex_ctrl);
        end
        checks++;
        if (stall_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall: stall_out=%0b required 0", stall_out);
        end
        #2 rst_n = 1'b1;
        clear_inputs();
        tick();
    endtask

    task automatic test_pass_through();
        clear_inputs();
        set_id(1'b1, 5'd1, 5'd2, 5'd5, C_ADD, 32'd20, 32'd45);
        id_imm    = 32'hFFFF_FFF4;
        id_alu_op = 4'h2;
        tick();
        checks++;
        if (ex_data1 !== 32'd20 || ex_data2 !== 32'd45) begin
            failures++;
            $display("FAIL pass_data: data1=%0d data2=%0d, required 20 45", ex_data1, ex_data2);
        end
        checks++;
        if (ex_valid !== 1'b1 || ex_ctrl !== C_ADD || ex_alu_op !== 4'h2) begin
            failures++;
            $display("FAIL pass_ctrl: valid=%0b ctrl=%h op=%h, required 1 80 2", ex_valid, ex_ctrl, ex_alu_op);
        end
        checks++;
        if (ex_rs !== 5'd1 || ex_rt !== 5'd2 || ex_dest !== 5'd5 || ex_imm !== 32'hFFFF_FFF4) begin
            failures++;
            $display("FAIL pass_fields: rs=%0d rt=%0d dest=%0d imm=%h, required 1 2 5 fffffff4",
                     ex_rs, ex_rt, ex_dest, ex_imm);
        end
        set_id(1'b0, 5'd1, 5'd2, 5'd5, C_ADD, 32'd20, 32'd45);
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00) begin
            failures++;
            $display("FAIL pass_invalid: valid=%0b ctrl=%h, required 0 00", ex_valid, ex_ctrl);
        end
    endtask

    task automatic test_bypass();
        clear_inputs();
        set_id(1'b1, 5'd3, 5'd2, 5'd7, C_ADD, 32'd10, 32'd45);
        wb_write = 1'b1; wb_reg = 5'd3; wb_data = 32'd99;
        tick();
        checks++;
        if (ex_data1 !== 32'd99 || ex_data2 !== 32'd45) begin
            failures++;
            $display("FAIL bypass_rs: data1=%0d data2=%0d, required 99 45", ex_data1, ex_data2);
        end
        wb_reg = 5'd2;
        tick();
        checks++;
        if (ex_data1 !== 32'd10 || ex_data2 !== 32'd99) begin
            failures++;
            $display("FAIL bypass_rt: data1=%0d data2=%0d, required 10 99", ex_data1, ex_data2);
        end
        wb_write = 1'b0; wb_reg = 5'd3;
        tick();
        checks++;
        if (ex_data1 !== 32'd10) begin
            failures++;
            $display("FAIL bypass_nowrite: data1=%0d required 10", ex_data1);
        end
        set_id(1'b1, 5'd0, 5'd0, 5'd7, C_ADD, 32'd10, 32'd7);
        wb_write = 1'b1; wb_reg = 5'd0; wb_data = 32'd99;
        tick();
        checks++;
        if (ex_data1 !== 32'd0 || ex_data2 !== 32'd0) begin
            failures++;
            $display("FAIL bypass_r0: data1=%0d data2=%0d, required 0 0", ex_data1, ex_data2);
        end
    endtask

    task automatic test_load_use();
        load_ex(5'd1, 5'd2, 5'd4, C_LW);
        set_id(1'b1, 5'd4, 5'd5, 5'd6, C_ADD, 32'd3, 32'd4);
        checks++;
        if (stall_out !== 1'b1) begin
            failures++;
            $display("FAIL lu_stall_rs: stall_out=%0b required 1", stall_out);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || stall_out !== 1'b0) begin
            failures++;
            $display("FAIL lu_bubble: valid=%0b ctrl=%h stall=%0b, required 0 00 0", ex_valid, ex_ctrl, stall_out);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_ctrl !== C_ADD || ex_rs !== 5'd4 || ex_dest !== 5'd6) begin
            failures++;
            $display("FAIL lu_enter: valid=%0b ctrl=%h rs=%0d dest=%0d, required 1 80 4 6",
                     ex_valid, ex_ctrl, ex_rs, ex_dest);
        end
        load_ex(5'd1, 5'd2, 5'd4, C_LW);
        set_id(1'b1, 5'd1, 5'd4, 5'd6, C_ADD, 32'd3, 32'd4);
        checks++;
        if (stall_out !== 1'b1) begin
            failures++;
            $display("FAIL lu_stall_rt: stall_out=%0b required 1", stall_out);
        end
        set_id(1'b1, 5'd1, 5'd4, 5'd6, C_ADDI, 32'd3, 32'd4);
        checks++;
        if (stall_out !== 1'b0) begin
            failures++;
            $display("FAIL lu_addi_rt: stall_out=%0b required 0", stall_out);
        end
        set_id(1'b1, 5'd1, 5'd4, 5'd0, C_SW, 32'd3, 32'd4);
        checks++;
        if (stall_out !== 1'b1) begin
            failures++;
            $display("FAIL lu_sw_rt: stall_out=%0b required 1", stall_out);
        end
    endtask

    task automatic test_flush();
        load_ex(5'd1, 5'd2, 5'd4, C_LW);
        set_id(1'b1, 5'd4, 5'd5, 5'd6, C_ADD, 32'd3, 32'd4);
        flush = 1'b1;
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00) begin
            failures++;
            $display("FAIL flush_over_stall: valid=%0b ctrl=%h, required 0 00", ex_valid, ex_ctrl);
        end
        set_id(1'b1, 5'd8, 5'd9, 5'd10, C_ADD, 32'd3, 32'd4);
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00) begin
            failures++;
            $display("FAIL flush_alone: valid=%0b ctrl=%h, required 0 00", ex_valid, ex_ctrl);
        end
        flush = 1'b0;
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_dest !== 5'd10) begin
            failures++;
            $display("FAIL flush_release: valid=%0b dest=%0d, required 1 10", ex_valid, ex_dest);
        end
    endtask

    task automatic test_no_false_stall();
        load_ex(5'd1, 5'd2, 5'd0, C_LW);
        set_id(1'b1, 5'd0, 5'd0, 5'd6, C_ADD, 32'd0, 32'd0);
        checks++;
        if (stall_out !== 1'b0) begin
            failures++;
            $display("FAIL nfs_dest0: stall_out=%0b required 0", stall_out);
        end
        load_ex(5'd1, 5'd2, 5'd4, C_LW);
        set_id(1'b1, 5'd5, 5'd6, 5'd7, C_ADD, 32'd0, 32'd0);
        checks++;
        if (stall_out !== 1'b0) begin
            failures++;
            $display("FAIL nfs_nomatch: stall_out=%0b required 0", stall_out);
        end
        set_id(1'b0, 5'd4, 5'd4, 5'd7, C_ADD, 32'd0, 32'd0);
        checks++;
        if (stall_out !== 1'b0) begin
            failures++;
            $display("FAIL nfs_idinvalid: stall_out=%0b required 0", stall_out);
        end
        load_ex(5'd1, 5'd2, 5'd4, C_ADD);
        set_id(1'b1, 5'd4, 5'd4, 5'd7, C_ADD, 32'd0, 32'd0);
        checks++;
        if (stall_out !== 1'b0) begin
            failures++;
            $display("FAIL nfs_notload: stall_out=%0b required 0", stall_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp1 [3];
        logic [AW-1:0] expd [3];
        exp1[0] = 32'h1111; exp1[1] = 32'h2222; exp1[2] = 32'h3333;
        expd[0] = 5'd11;    expd[1] = 5'd12;    expd[2] = 5'd13;
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 5'(i + 1), 5'(i + 20), expd[i], C_ADD, exp1[i], ~exp1[i]);
            tick();
            checks++;
            if (ex_valid !== 1'b1 || ex_data1 !== exp1[i] || ex_data2 !== ~exp1[i] || ex_dest !== expd[i]) begin
                failures++;
                $display("FAIL b2b_%0d: valid=%0b data1=%h data2=%h dest=%0d, required 1 %h %h %0d",
                         i, ex_valid, ex_data1, ex_data2, ex_dest, exp1[i], ~exp1[i], expd[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_bypass();
        test_load_use();
        test_flush();
        test_no_false_stall();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
